// File: rtl/lmc1992.sv
// STE Microwire master emulation feeding an LMC1992-style mix/volume stage.
// CPU-written DATA/MASK frames are shifted out, decoded, and applied to the YM/DMA audio mix.
module lmc1992 #(
    parameter int BIT_CYCLES = 32
) (
    input  logic        clk_32,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic [4:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic        rw,
    input  logic        sel,
    output logic [15:0] dout,
    output logic        mw_busy,
    input  logic [9:0]  ym_l,
    input  logic [9:0]  ym_r,
    input  logic [7:0]  ste_l,
    input  logic [7:0]  ste_r,
    output logic [14:0] audio_mix_l,
    output logic [14:0] audio_mix_r
);

    localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [4:0] ADDR_DATA = 5'h11;
    localparam logic [4:0] ADDR_MASK = 5'h12;

    typedef enum logic {IDLE, SHIFT} mw_state_t;

    mw_state_t   state_reg, state_next;
    logic [15:0] data_reg, data_next;
    logic [15:0] mask_reg, mask_next;
    logic [PW-1:0] pre_reg, pre_next;
    logic [3:0]  bit_reg, bit_next;
    logic [10:0] acc_reg, acc_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [1:0]  mix_reg, mix_next;
    logic [3:0]  bass_reg, bass_next;
    logic [3:0]  treble_reg, treble_next;
    logic [5:0]  master_reg, master_next;
    logic [5:0]  left_reg, left_next;
    logic [5:0]  right_reg, right_next;
    logic        wr_d_reg;

    logic        wr_req, wr_stb, bit_end;
    logic [10:0] acc_shift;
    logic [3:0]  cnt_shift;
    logic [7:0]  tone_unused;

    // Tone settings are kept for completeness but drive nothing.
    assign tone_unused = {bass_reg, treble_reg};

    assign wr_req    = sel & ~rw;
    assign wr_stb    = wr_req & ~wr_d_reg & uds & lds;
    assign bit_end   = (pre_reg == PW'(BIT_CYCLES - 1));
    assign acc_shift = mask_reg[15] ? {acc_reg[9:0], data_reg[15]} : acc_reg;
    assign cnt_shift = (mask_reg[15] && cnt_reg != 4'hF) ? cnt_reg + 4'd1 : cnt_reg;
    assign mw_busy   = (state_reg == SHIFT);

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        mask_next   = mask_reg;
        pre_next    = pre_reg;
        bit_next    = bit_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        mix_next    = mix_reg;
        bass_next   = bass_reg;
        treble_next = treble_reg;
        master_next = master_reg;
        left_next   = left_reg;
        right_next  = right_reg;
        case (state_reg)
            IDLE: begin
                if (wr_stb && addr == ADDR_DATA) begin
                    data_next  = din;
                    pre_next   = '0;
                    bit_next   = 4'd0;
                    acc_next   = 11'd0;
                    cnt_next   = 4'd0;
                    state_next = SHIFT;
                end else if (wr_stb && addr == ADDR_MASK) begin
                    mask_next = din;
                end
            end
            SHIFT: begin
                pre_next = bit_end ? '0 : pre_reg + PW'(1);
                if (bit_end) begin
                    acc_next  = acc_shift;
                    cnt_next  = cnt_shift;
                    data_next = {data_reg[14:0], data_reg[15]};
                    mask_next = {mask_reg[14:0], mask_reg[15]};
                    bit_next  = bit_reg + 4'd1;
                    // Last bit: the frame is complete, decode with the final accumulator value.
                    if (bit_reg == 4'd15) begin
                        state_next = IDLE;
                        if (cnt_shift == 4'd11 && acc_shift[10:9] == 2'b10) begin
                            case (acc_shift[8:6])
                                3'b000:  mix_next    = acc_shift[1:0];
                                3'b001:  bass_next   = acc_shift[3:0];
                                3'b010:  treble_next = acc_shift[3:0];
                                3'b011:  master_next = acc_shift[5:0];
                                3'b100:  right_next  = acc_shift[5:0];
                                3'b101:  left_next   = acc_shift[5:0];
                                default: ;
                            endcase
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_32) begin
        if (reset) begin
            state_reg  <= IDLE;
            data_reg   <= 16'h0000;
            mask_reg   <= 16'h07FF;
            pre_reg    <= '0;
            bit_reg    <= 4'd0;
            acc_reg    <= 11'd0;
            cnt_reg    <= 4'd0;
            mix_reg    <= 2'b01;
            bass_reg   <= 4'd6;
            treble_reg <= 4'd6;
            master_reg <= 6'd40;
            left_reg   <= 6'd20;
            right_reg  <= 6'd20;
            wr_d_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            mask_reg   <= mask_next;
            pre_reg    <= pre_next;
            bit_reg    <= bit_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            mix_reg    <= mix_next;
            bass_reg   <= bass_next;
            treble_reg <= treble_next;
            master_reg <= master_next;
            left_reg   <= left_next;
            right_reg  <= right_next;
            wr_d_reg   <= wr_req;
        end
    end

    always_comb begin
        dout = 16'h0000;
        if (addr == ADDR_DATA)      dout = data_reg;
        else if (addr == ADDR_MASK) dout = mask_reg;
    end

    logic [5:0]       master_cl;
    logic [1:0][14:0] out_arr;

    assign master_cl = (master_reg > 6'd40) ? 6'd40 : master_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [9:0]         ym_c;
            logic [7:0]         ste_c;
            logic [5:0]         side_c, side_cl, atten_n;
            logic signed [14:0] y_ext, s_ext, mix_sum;
            logic [8:0]         mant_next;
            logic [4:0]         sh_next;
            logic signed [14:0] m1_reg;
            logic [8:0]         mant1_reg;
            logic [4:0]         sh1_reg;
            logic [14:0]        out_reg;
            logic signed [23:0] m_ext, mant_ext, prod, shifted;

            assign ym_c    = (gi == 0) ? ym_l : ym_r;
            assign ste_c   = (gi == 0) ? ste_l : ste_r;
            assign side_c  = (gi == 0) ? left_reg : right_reg;
            assign side_cl = (side_c > 6'd20) ? 6'd20 : side_c;
            assign y_ext   = {ym_c[9], ym_c, ym_c[9:6]};
            assign s_ext   = {ste_c[7], ste_c, ste_c[7:2]};
            assign atten_n = (6'd40 - master_cl) + (6'd20 - side_cl);
            assign sh_next = 5'd8 + 5'(atten_n / 6'd3);

            always_comb begin
                case (mix_reg)
                    2'b00:   mix_sum = (y_ext >>> 2) + s_ext;
                    2'b10:   mix_sum = s_ext;
                    default: mix_sum = y_ext + s_ext;
                endcase
            end

            // Roughly 2 dB per step: mantissa cycles through 1, 0.79, 0.63 while the shift grows.
            always_comb begin
                case (atten_n % 6'd3)
                    6'd0:    mant_next = 9'd256;
                    6'd1:    mant_next = 9'd203;
                    default: mant_next = 9'd162;
                endcase
            end

            assign m_ext    = 24'(m1_reg);
            assign mant_ext = {15'd0, mant1_reg};
            assign prod     = m_ext * mant_ext;
            assign shifted  = prod >>> sh1_reg;

            always_ff @(posedge clk_32) begin
                if (reset) begin
                    m1_reg    <= '0;
                    mant1_reg <= '0;
                    sh1_reg   <= '0;
                    out_reg   <= '0;
                end else begin
                    m1_reg    <= mix_sum;
                    mant1_reg <= mant_next;
                    sh1_reg   <= sh_next;
                    out_reg   <= shifted[14:0];
                end
            end

            assign out_arr[gi] = out_reg;
        end
    endgenerate

    assign audio_mix_l = out_arr[0];
    assign audio_mix_r = out_arr[1];

endmodule

// File: tb/tb_lmc1992.sv
// Self-checking bench for lmc1992: directed scenarios plus randomized Microwire frames and audio,
// compared against an arithmetic model of the command decoder and volume stage.
module tb_lmc1992;

    logic        clk_32 = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [4:0]  addr;
    logic        uds, lds, rw, sel;
    logic [15:0] dout;
    logic        mw_busy;
    logic [9:0]  ym_l, ym_r;
    logic [7:0]  ste_l, ste_r;
    logic [14:0] audio_mix_l, audio_mix_r;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mix, m_master, m_left, m_right;
    logic [15:0] m_data, m_mask;

    lmc1992 #(.BIT_CYCLES(32)) dut (
        .clk_32(clk_32), .reset(reset), .din(din), .addr(addr), .uds(uds), .lds(lds),
        .rw(rw), .sel(sel), .dout(dout), .mw_busy(mw_busy),
        .ym_l(ym_l), .ym_r(ym_r), .ste_l(ste_l), .ste_r(ste_r),
        .audio_mix_l(audio_mix_l), .audio_mix_r(audio_mix_r)
    );

    always #5 clk_32 = ~clk_32;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mix = 1; m_master = 40; m_left = 20; m_right = 20;
        m_data = 16'h0000; m_mask = 16'h07FF;
    endfunction

    // Serial frame semantics: walk DATA MSB first, keep the bits MASK selects.
    function automatic void model_frame(input logic [15:0] val);
        int cnt = 0;
        logic [10:0] acc = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m_mask[i]) begin
                acc = {acc[9:0], val[i]};
                cnt++;
            end
        end
        m_data = val;
        if (cnt == 11 && acc[10:9] == 2'b10) begin
            case (acc[8:6])
                3'd0: m_mix    = int'(acc[1:0]);
                3'd3: m_master = int'(acc[5:0]);
                3'd4: m_right  = int'(acc[5:0]);
                3'd5: m_left   = int'(acc[5:0]);
                default: ;
            endcase
        end
    endfunction

    function automatic logic [14:0] exp_audio(input logic [9:0] ym, input logic [7:0] ste, input int side);
        int y, s, sum, mst, sd, n, mant, sh, res;
        logic [31:0] r;
        y = $signed(ym) * 16 + int'(ym[9:6]);
        s = $signed(ste) * 64 + int'(ste[7:2]);
        if (m_mix == 0)      sum = (y >>> 2) + s;
        else if (m_mix == 2) sum = s;
        else                 sum = y + s;
        sum = sum & 32'h7FFF;
        if (sum >= 16384) sum = sum - 32768;
        mst  = (m_master > 40) ? 40 : m_master;
        sd   = (side > 20) ? 20 : side;
        n    = (40 - mst) + (20 - sd);
        mant = (n % 3 == 0) ? 256 : ((n % 3 == 1) ? 203 : 162);
        sh   = 8 + n / 3;
        res  = (sum * mant) >>> sh;
        r    = res;
        return r[14:0];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_32);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [15:0] d, input logic u, input logic l);
        sel = 1'b0; rw = 1'b1;
        @(posedge clk_32); #1;
        addr = a; din = d; uds = u; lds = l; rw = 1'b0; sel = 1'b1;
        @(posedge clk_32); #1;
        sel = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0;
    endtask

    task automatic drive_audio(input logic [9:0] yl, input logic [9:0] yr,
                               input logic [7:0] sl, input logic [7:0] sr);
        ym_l = yl; ym_r = yr; ste_l = sl; ste_r = sr;
        repeat (2) @(posedge clk_32);
        #1;
    endtask

    task automatic audio_model_check(input string tag);
        check({tag, "_l"}, {17'd0, audio_mix_l}, {17'd0, exp_audio(ym_l, ste_l, m_left)});
        check({tag, "_r"}, {17'd0, audio_mix_r}, {17'd0, exp_audio(ym_r, ste_r, m_right)});
    endtask

    // mode 0: plain transfer; 1: writes poked while busy; 2: reset asserted around bit 8.
    task automatic mw_xfer(input logic [15:0] val, input int mode);
        int k = 0;
        logic [15:0] rot4 = {val[11:0], val[15:12]};
        bus_write(5'h11, val, 1'b1, 1'b1);
        addr = 5'h11;
        while (mw_busy && k < 2000) begin
            if (k == 140) check("rd_mid", {16'd0, dout}, {16'd0, rot4});
            if (mode == 1) begin
                if (k == 200) begin addr = 5'h11; din = 16'hFFFF; uds = 1; lds = 1; rw = 0; sel = 1; end
                if (k == 203) begin sel = 0; rw = 1; end
                if (k == 300) begin addr = 5'h12; din = 16'h0000; rw = 0; sel = 1; end
                if (k == 303) begin sel = 0; rw = 1; addr = 5'h11; end
            end
            if (mode == 2 && k == 260) begin
                reset = 1'b1;
                @(posedge clk_32); #1;
                reset = 1'b0;
                model_reset();
                break;
            end
            k++;
            @(posedge clk_32); #1;
        end
        if (mode == 2) begin
            check("rst_busy", {31'd0, mw_busy}, 32'd0);
        end else begin
            check("busy_len", k, 512);
            model_frame(val);
        end
        check("rd_data", {16'd0, dout}, {16'd0, m_data});
        addr = 5'h12; #1;
        check("rd_mask", {16'd0, dout}, {16'd0, m_mask});
        addr = 5'h11;
    endtask

    initial begin
        reset = 1'b1; din = '0; addr = 5'h11; uds = 0; lds = 0; rw = 1; sel = 0;
        ym_l = '0; ym_r = '0; ste_l = '0; ste_r = '0;
        model_reset();
        repeat (4) @(posedge clk_32);
        #1;
        reset = 1'b0;
        check("rst_busy0", {31'd0, mw_busy}, 32'd0);
        check("rst_data", {16'd0, dout}, 32'h0000);
        addr = 5'h12; #1;
        check("rst_mask", {16'd0, dout}, 32'h07FF);
        addr = 5'h03; #1;
        check("rd_other", {16'd0, dout}, 32'h0000);
        addr = 5'h11;

        drive_audio(10'd100, 10'd100, 8'd0, 8'd0);
        check("dflt_l", {17'd0, audio_mix_l}, 32'd1601);
        check("dflt_r", {17'd0, audio_mix_r}, 32'd1601);

        mw_xfer(16'h04E5, 0);
        drive_audio(10'd100, 10'd100, 8'd0, 8'd0);
        check("master37_l", {17'd0, audio_mix_l}, 32'd800);
        check("master37_r", {17'd0, audio_mix_r}, 32'd800);

        do_reset();
        mw_xfer(16'h0553, 0);
        drive_audio(10'd100, 10'd100, 8'd0, 8'd0);
        check("left19_l", {17'd0, audio_mix_l}, 32'd1269);
        check("left19_r", {17'd0, audio_mix_r}, 32'd1601);

        do_reset();
        mw_xfer(16'h0402, 0);
        drive_audio(10'd100, 10'd100, 8'd16, 8'd0);
        check("mix10_l", {17'd0, audio_mix_l}, 32'd1028);
        mw_xfer(16'h0400, 0);
        drive_audio(10'd100, 10'd100, 8'd16, 8'd0);
        check("mix00_l", {17'd0, audio_mix_l}, 32'd1428);

        do_reset();
        bus_write(5'h11, 16'h04C0, 1'b1, 1'b0);
        check("byte_u_busy", {31'd0, mw_busy}, 32'd0);
        bus_write(5'h11, 16'h04C0, 1'b0, 1'b1);
        check("byte_l_busy", {31'd0, mw_busy}, 32'd0);
        addr = 5'h11; #1;
        check("byte_data", {16'd0, dout}, 32'h0000);

        bus_write(5'h12, 16'hFFFF, 1'b1, 1'b1);
        m_mask = 16'hFFFF;
        addr = 5'h12; #1;
        check("mask_ffff", {16'd0, dout}, 32'hFFFF);
        mw_xfer(16'h04E5, 1);
        drive_audio(10'd100, 10'd100, 8'd0, 8'd0);
        check("ign16_l", {17'd0, audio_mix_l}, 32'd1601);
        bus_write(5'h12, 16'h07FF, 1'b1, 1'b1);
        m_mask = 16'h07FF;

        mw_xfer(16'h04C0, 2);
        drive_audio(10'd100, 10'd100, 8'd0, 8'd0);
        check("abort_l", {17'd0, audio_mix_l}, 32'd1601);
        check("abort_r", {17'd0, audio_mix_r}, 32'd1601);

        for (int it = 0; it < 36; it++) begin
            int r = $urandom_range(0, 9);
            logic [15:0] v;
            if (r == 0) begin
                v = 16'($urandom);
                bus_write(5'h12, v, 1'b1, 1'b1);
                m_mask = v;
            end else if (r == 1) begin
                bus_write(5'h12, 16'h07FF, 1'b1, 1'b1);
                m_mask = 16'h07FF;
            end
            if (r == 2) v = 16'($urandom);
            else        v = {5'($urandom), 2'b10, 3'($urandom_range(0, 7)), 6'($urandom)};
            mw_xfer(v, 0);
            for (int j = 0; j < 2; j++) begin
                drive_audio(10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom));
                audio_model_check("rand_audio");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
